mac_table_ctrl: RTL and testbench
=================================

// Module: mac_table_ctrl
// PURPOSE
//  Sequencer for the switch's MAC learning table (external CAM of MACs + RAM of ports).
//  Sits between output-port lookup and the CAM/RAM pair; serialises learn + lookup per packet.
//  Learns the source MAC/port and resolves the destination MAC to a one-hot output-port vector.
//  Resolves to a flood vector on miss, broadcast or multicast.
// PARAMETERS
//  ADDR_BITS      4        CAM/RAM index width; table holds 2**ADDR_BITS entries
//  FLOOD_MASK     16'h0055 MAC output-port bits used for flooding
//  BUSY_TIMEOUT   15       max cycles waiting on cam_busy before forcing a miss
// PORTS
//  clk             in   1   clock
//  reset           in   1   synchronous, active-high reset
//  lkup_req        in   1   request; held high until lkup_done
//  lkup_rdy        out  1   controller idle, request accepted this cycle if lkup_req
//  lkup_dst_mac    in   48  destination MAC
//  lkup_src_mac    in   48  source MAC
//  lkup_src_port   in   16  one-hot ingress port (0 = from CPU)
//  lkup_done       out  1   one-cycle pulse: result valid
//  lkup_hit        out  1   destination found in table (valid with lkup_done)
//  lkup_dst_port   out  16  output-port vector (valid with lkup_done)
//  cam_cmp_din     out  48  CAM compare key
//  cam_din         out  48  CAM write data
//  cam_we          out  1   CAM write strobe
//  cam_wr_addr     out  ADDR_BITS  CAM write index
//  cam_busy        in   1   CAM busy
//  cam_match       in   1   compare hit
//  cam_match_addr  in   ADDR_BITS  hit index
//  ram_addr        out  ADDR_BITS  RAM address
//  ram_din         out  56  {src_port[7:0], src_mac}
//  ram_we          out  1   RAM write strobe
//  ram_dout        in   56  RAM read data, 1-cycle read latency
// BEHAVIOUR
//  - Reset: state IDLE.
//  - Reset: lkup_rdy=1; lkup_done, lkup_hit, cam_we, ram_we = 0.
//  - Reset: lkup_dst_port, cam_*/ram_* data and addresses = 0; wr_ptr = 0.
//  - Any reset mid-operation aborts the request with no lkup_done.
//  - IDLE: on lkup_req, latch dst/src MAC and src_port.
//    - src multicast (src_mac[40]): go DST_CMP.
//    - Otherwise: go SRC_CMP.
//  - SRC_CMP: drive cam_cmp_din = src_mac; wait !cam_busy.
//    - Hit: RAM_WR at cam_match_addr (refresh port).
//    - Miss: CAM_WR.
//  - CAM_WR: cam_wr_addr = wr_ptr, cam_din = src_mac, cam_we = 1 for exactly 1 cycle.
//    - Then wait !cam_busy and go RAM_WR at wr_ptr.
//    - wr_ptr += 1, wrapping 2**ADDR_BITS-1 -> 0 (FIFO replacement; oldest entry overwritten when full).
//  - RAM_WR: ram_we = 1 for 1 cycle; ram_din = {src_port[7:0], src_mac}. Then DST_CMP.
//  - DST_CMP:
//    - dst_mac[40] set (bcast/mcast): DONE, flood, no CAM access.
//    - Otherwise: cam_cmp_din = dst_mac; wait !cam_busy.
//      - Hit: RAM_RD with ram_addr = cam_match_addr.
//      - Miss: DONE, flood.
//  - RAM_RD: one wait cycle for RAM latency. Then DONE with lkup_hit = 1 and
//    dst = {8'b0, ram_dout[55:48]} & ~src_port.
//    - dst == 0 (dest on ingress port): lkup_dst_port = 0 (drop); lkup_hit stays 1.
//  - Flood: lkup_dst_port = ~src_port & FLOOD_MASK; lkup_hit = 0.
//  - DONE: lkup_done = 1 for 1 cycle; outputs held until the next DONE; return to IDLE.
//    - lkup_rdy is high only in IDLE.
//  - Busy watchdog: counter resets on entry to each wait state.
//    - SRC_CMP timeout: treated as a miss.
//    - DST_CMP timeout: flood.
//    - CAM_WR timeout: proceed to RAM_WR.
//  - Latency, idle CAM, no learn:
//    - Known src, dst hit: 6 cycles req -> done.
//    - Src miss adds 2 cycles.
// CONFIGURATION
//  MAC_TABLE_STATS_EN defined: adds outputs hit_count[31:0], miss_count[31:0], learn_count[31:0].
//    - Each increments in DONE (hit/miss) or CAM_WR (learn); saturates at 32'hFFFFFFFF.
//    - Cleared by reset.
//  Undefined: ports absent; no counters.
// TESTING
//  1. Empty table; req src=A port 0x0001, dst=B:
//     -> CAM write addr 0; RAM write {01,A}; done, hit=0, dst_port=0x0054.
//  2. Learned A on port 0x0004; req src=B port 0x0001, dst=A:
//     -> done, hit=1, dst_port=0x0004.
//  3. dst=FF:FF:FF:FF:FF:FF, src port 0x0010:
//     -> no dst compare, dst_port=0x0045, hit=0.
//  4. Learn 17 distinct MACs (ADDR_BITS=4):
//     -> wr_ptr wraps; 17th overwrites index 0; first MAC then misses.
//  5. Hold cam_busy high 20 cycles in SRC_CMP:
//     -> timeout at 15; miss path; done still issued.
//  6. Assert reset in RAM_RD:
//     -> no lkup_done; next cycle lkup_rdy=1, all strobes 0, wr_ptr=0.

Source files
------------

// File: rtl/mac_table_ctrl.sv
// rtl/mac_table_ctrl.sv - MAC learning table sequencer: learns source MAC/port, resolves destination port vector.
// Optional hit/miss/learn statistics counters enabled by defining MAC_TABLE_STATS_EN.
module mac_table_ctrl #(
  parameter int          ADDR_BITS    = 4,
  parameter logic [15:0] FLOOD_MASK   = 16'h0055,
  parameter int          BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lkup_req,
  output logic                 lkup_rdy,
  input  logic [47:0]          lkup_dst_mac,
  input  logic [47:0]          lkup_src_mac,
  input  logic [15:0]          lkup_src_port,
  output logic                 lkup_done,
  output logic                 lkup_hit,
  output logic [15:0]          lkup_dst_port,
  output logic [47:0]          cam_cmp_din,
  output logic [47:0]          cam_din,
  output logic                 cam_we,
  output logic [ADDR_BITS-1:0] cam_wr_addr,
  input  logic                 cam_busy,
  input  logic                 cam_match,
  input  logic [ADDR_BITS-1:0] cam_match_addr,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [55:0]          ram_din,
  output logic                 ram_we,
`ifdef MAC_TABLE_STATS_EN
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count,
  output logic [31:0]          learn_count,
`endif
  input  logic [55:0]          ram_dout
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SRC_CMP, S_CAM_WR, S_CAM_WAIT, S_RAM_WR,
    S_DST_CMP, S_RAM_RD, S_RAM_WAIT, S_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [47:0]            dst_mac_q, dst_mac_d;
  logic [47:0]            src_mac_q, src_mac_d;
  logic [15:0]            src_port_q, src_port_d;
  logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [47:0]            cmp_q, cmp_d;
  logic [47:0]            cam_din_q, cam_din_d;
  logic [ADDR_BITS-1:0]   cam_wr_addr_q, cam_wr_addr_d;
  logic [ADDR_BITS-1:0]   ram_addr_q, ram_addr_d;
  logic [55:0]            ram_din_q, ram_din_d;
  logic                   hit_q, hit_d;
  logic [15:0]            dst_port_q, dst_port_d;

  logic                   tmo_hit;
  logic [15:0]            flood_vec;
  logic [15:0]            ram_dst;
  logic                   unused_ram_low;

  assign tmo_hit        = (tmo_q == TW'(BUSY_TIMEOUT - 1));
  assign flood_vec      = ~src_port_q & FLOOD_MASK;
  assign ram_dst        = {8'b0, ram_dout[55:48]} & ~src_port_q;
  assign unused_ram_low = ^ram_dout[47:0];

  always_comb begin
    state_d       = state_q;
    dst_mac_d     = dst_mac_q;
    src_mac_d     = src_mac_q;
    src_port_d    = src_port_q;
    wr_ptr_d      = wr_ptr_q;
    tmo_d         = tmo_q;
    cmp_d         = cmp_q;
    cam_din_d     = cam_din_q;
    cam_wr_addr_d = cam_wr_addr_q;
    ram_addr_d    = ram_addr_q;
    ram_din_d     = ram_din_q;
    hit_d         = hit_q;
    dst_port_d    = dst_port_q;

    unique case (state_q)
      S_IDLE: begin
        if (lkup_req) begin
          dst_mac_d  = lkup_dst_mac;
          src_mac_d  = lkup_src_mac;
          src_port_d = lkup_src_port;
          tmo_d      = '0;
          if (lkup_src_mac[40]) begin
            // Multicast sources are never learned.
            if (!lkup_dst_mac[40]) cmp_d = lkup_dst_mac;
            state_d = S_DST_CMP;
          end else begin
            cmp_d   = lkup_src_mac;
            state_d = S_SRC_CMP;
          end
        end
      end
      S_SRC_CMP: begin
        if (!cam_busy && cam_match) begin
          ram_addr_d = cam_match_addr;
          ram_din_d  = {src_port_q[7:0], src_mac_q};
          state_d    = S_RAM_WR;
        end else if (!cam_busy || tmo_hit) begin
          cam_wr_addr_d = wr_ptr_q;
          cam_din_d     = src_mac_q;
          ram_addr_d    = wr_ptr_q;
          ram_din_d     = {src_port_q[7:0], src_mac_q};
          state_d       = S_CAM_WR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CAM_WR: begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        tmo_d    = '0;
        state_d  = S_CAM_WAIT;
      end
      S_CAM_WAIT: begin
        if (!cam_busy || tmo_hit) state_d = S_RAM_WR;
        else                      tmo_d   = tmo_q + 1'b1;
      end
      S_RAM_WR: begin
        tmo_d = '0;
        if (!dst_mac_q[40]) cmp_d = dst_mac_q;
        state_d = S_DST_CMP;
      end
      S_DST_CMP: begin
        if (dst_mac_q[40]) begin
          hit_d      = 1'b0;
          dst_port_d = flood_vec;
          state_d    = S_DONE;
        end else if (!cam_busy && cam_match) begin
          ram_addr_d = cam_match_addr;
          state_d    = S_RAM_RD;
        end else if (!cam_busy || tmo_hit) begin
          hit_d      = 1'b0;
          dst_port_d = flood_vec;
          state_d    = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RAM_RD: state_d = S_RAM_WAIT;
      S_RAM_WAIT: begin
        // ram_dout reflects ram_addr presented during S_RAM_RD.
        hit_d      = 1'b1;
        dst_port_d = ram_dst;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      dst_mac_q     <= '0;
      src_mac_q     <= '0;
      src_port_q    <= '0;
      wr_ptr_q      <= '0;
      tmo_q         <= '0;
      cmp_q         <= '0;
      cam_din_q     <= '0;
      cam_wr_addr_q <= '0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      hit_q         <= 1'b0;
      dst_port_q    <= '0;
    end else begin
      state_q       <= state_d;
      dst_mac_q     <= dst_mac_d;
      src_mac_q     <= src_mac_d;
      src_port_q    <= src_port_d;
      wr_ptr_q      <= wr_ptr_d;
      tmo_q         <= tmo_d;
      cmp_q         <= cmp_d;
      cam_din_q     <= cam_din_d;
      cam_wr_addr_q <= cam_wr_addr_d;
      ram_addr_q    <= ram_addr_d;
      ram_din_q     <= ram_din_d;
      hit_q         <= hit_d;
      dst_port_q    <= dst_port_d;
    end
  end

`ifdef MAC_TABLE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q, learn_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      learn_cnt_q <= '0;
    end else begin
      if (state_q == S_DONE && hit_q && hit_cnt_q != '1)    hit_cnt_q   <= hit_cnt_q + 1'b1;
      if (state_q == S_DONE && !hit_q && miss_cnt_q != '1)  miss_cnt_q  <= miss_cnt_q + 1'b1;
      if (state_q == S_CAM_WR && learn_cnt_q != '1)         learn_cnt_q <= learn_cnt_q + 1'b1;
    end
  end

  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;
  assign learn_count = learn_cnt_q;
`endif

  assign lkup_rdy      = (state_q == S_IDLE);
  assign lkup_done     = (state_q == S_DONE);
  assign lkup_hit      = hit_q;
  assign lkup_dst_port = dst_port_q;
  assign cam_cmp_din   = cmp_q;
  assign cam_din       = cam_din_q;
  assign cam_we        = (state_q == S_CAM_WR);
  assign cam_wr_addr   = cam_wr_addr_q;
  assign ram_addr      = ram_addr_q;
  assign ram_din       = ram_din_q;
  assign ram_we        = (state_q == S_RAM_WR);

endmodule

// File: tb/tb_mac_table_ctrl.sv
// tb/tb_mac_table_ctrl.sv - directed bench for mac_table_ctrl with behavioural CAM/RAM models.
module tb_mac_table_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        lkup_req;
  logic        lkup_rdy;
  logic [47:0] lkup_dst_mac, lkup_src_mac;
  logic [15:0] lkup_src_port;
  logic        lkup_done, lkup_hit;
  logic [15:0] lkup_dst_port;
  logic [47:0] cam_cmp_din, cam_din;
  logic        cam_we;
  logic [3:0]  cam_wr_addr;
  logic        cam_busy, cam_match;
  logic [3:0]  cam_match_addr;
  logic [3:0]  ram_addr;
  logic [55:0] ram_din;
  logic        ram_we;
  logic [55:0] ram_dout;
`ifdef MAC_TABLE_STATS_EN
  logic [31:0] hit_count, miss_count, learn_count;
`endif

  always #5 clk = ~clk;

  mac_table_ctrl dut (
    .clk(clk), .reset(reset),
    .lkup_req(lkup_req), .lkup_rdy(lkup_rdy),
    .lkup_dst_mac(lkup_dst_mac), .lkup_src_mac(lkup_src_mac), .lkup_src_port(lkup_src_port),
    .lkup_done(lkup_done), .lkup_hit(lkup_hit), .lkup_dst_port(lkup_dst_port),
    .cam_cmp_din(cam_cmp_din), .cam_din(cam_din), .cam_we(cam_we), .cam_wr_addr(cam_wr_addr),
    .cam_busy(cam_busy), .cam_match(cam_match), .cam_match_addr(cam_match_addr),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
`ifdef MAC_TABLE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count), .learn_count(learn_count),
`endif
    .ram_dout(ram_dout)
  );

  // CAM and RAM models
  logic [47:0] cam_mac [16];
  logic [15:0] cam_vld = '0;
  logic [55:0] ram_mem [16];

  always_comb begin
    cam_match      = 1'b0;
    cam_match_addr = '0;
    for (int i = 15; i >= 0; i--) begin
      if (cam_vld[i] && cam_mac[i] == cam_cmp_din) begin
        cam_match      = 1'b1;
        cam_match_addr = 4'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (cam_we) begin
      cam_mac[cam_wr_addr] <= cam_din;
      cam_vld[cam_wr_addr] <= 1'b1;
    end
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  localparam logic [47:0] MAC_A  = 48'h0011_2233_4455;
  localparam logic [47:0] MAC_B  = 48'h00AA_BBCC_DDEE;
  localparam logic [47:0] MAC_C  = 48'h0012_3456_789A;
  localparam logic [47:0] MAC_D  = 48'h0066_7788_99AA;
  localparam logic [47:0] MAC_E  = 48'h0033_4455_6677;
  localparam logic [47:0] MAC_F  = 48'h0044_5566_7788;
  localparam logic [47:0] MAC_MC = 48'h0100_5E00_0001;
  localparam logic [47:0] MAC_BC = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MAC_M  = 48'h0200_0000_0000;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit          seen_done;
  int          lat, n_cam_we, n_ram_we, first_cam_we_c;
  logic [3:0]  last_cam_addr, last_ram_addr;
  logic [47:0] last_cam_din;
  logic [55:0] last_ram_din;
  logic        obs_hit;
  logic [15:0] obs_dst;

  task automatic run_req(input logic [47:0] src, input logic [15:0] sport, input logic [47:0] dst,
                         input int busy_cycles, input int abort_at);
    bit stop;
    @(negedge clk);
    seen_done = 0; lat = 0; n_cam_we = 0; n_ram_we = 0; first_cam_we_c = 0;
    stop = 0;
    lkup_src_mac = src; lkup_src_port = sport; lkup_dst_mac = dst;
    cam_busy = (busy_cycles > 0);
    lkup_req = 1'b1;
    for (int c = 1; c <= 80 && !stop; c++) begin
      @(negedge clk);
      if (c >= busy_cycles) cam_busy = 1'b0;
      if (cam_we) begin
        n_cam_we++;
        last_cam_addr = cam_wr_addr;
        last_cam_din  = cam_din;
        if (first_cam_we_c == 0) first_cam_we_c = c;
      end
      if (ram_we) begin
        n_ram_we++;
        last_ram_addr = ram_addr;
        last_ram_din  = ram_din;
      end
      if (lkup_done) begin
        seen_done = 1; lat = c; obs_hit = lkup_hit; obs_dst = lkup_dst_port;
        lkup_req = 1'b0; stop = 1;
      end else if (c == abort_at) begin
        reset = 1'b1; lkup_req = 1'b0; stop = 1;
      end
    end
    lkup_req = 1'b0;
    cam_busy = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rdy"},   lkup_rdy, 1);
    check({tag, "_done"},  lkup_done, 0);
    check({tag, "_camwe"}, cam_we, 0);
    check({tag, "_ramwe"}, ram_we, 0);
    check({tag, "_hit"},   lkup_hit, 0);
    check({tag, "_dport"}, lkup_dst_port, 0);
    check({tag, "_cwa"},   cam_wr_addr, 0);
    check({tag, "_raddr"}, ram_addr, 0);
  endtask

  initial begin
    reset = 1'b1; lkup_req = 1'b0; cam_busy = 1'b0;
    lkup_dst_mac = '0; lkup_src_mac = '0; lkup_src_port = '0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_rdin", ram_din, 0);
    check("rst_cmp", cam_cmp_din, 0);
    reset = 1'b0;

    // Empty table: learn A, B unknown -> flood
    run_req(MAC_A, 16'h0001, MAC_B, 0, 0);
    check("t1_done", seen_done, 1);
    check("t1_lat", lat, 6);
    check("t1_camwe", n_cam_we, 1);
    check("t1_cam_addr", last_cam_addr, 0);
    check("t1_cam_din", last_cam_din, MAC_A);
    check("t1_ram_addr", last_ram_addr, 0);
    check("t1_ram_din", last_ram_din, {8'h01, MAC_A});
    check("t1_hit", obs_hit, 0);
    check("t1_dst", obs_dst, 16'h0054);

    // A moves to port 4: refresh only
    run_req(MAC_A, 16'h0004, MAC_B, 0, 0);
    check("t2a_lat", lat, 4);
    check("t2a_camwe", n_cam_we, 0);
    check("t2a_ramwe", n_ram_we, 1);
    check("t2a_ram_din", last_ram_din, {8'h04, MAC_A});
    check("t2a_dst", obs_dst, 16'h0051);

    // New src B, dst A hits
    run_req(MAC_B, 16'h0001, MAC_A, 0, 0);
    check("t2b_lat", lat, 8);
    check("t2b_cam_addr", last_cam_addr, 1);
    check("t2b_hit", obs_hit, 1);
    check("t2b_dst", obs_dst, 16'h0004);

    // Known src, dst hit: base latency
    run_req(MAC_B, 16'h0001, MAC_A, 0, 0);
    check("t2c_lat", lat, 6);
    check("t2c_camwe", n_cam_we, 0);
    check("t2c_hit", obs_hit, 1);
    check("t2c_dst", obs_dst, 16'h0004);

    // Destination on ingress port -> drop, hit stays 1
    run_req(MAC_C, 16'h0004, MAC_A, 0, 0);
    check("drop_cam_addr", last_cam_addr, 2);
    check("drop_hit", obs_hit, 1);
    check("drop_dst", obs_dst, 16'h0000);

    // Broadcast destination
    run_req(MAC_B, 16'h0010, MAC_BC, 0, 0);
    check("t3_lat", lat, 4);
    check("t3_camwe", n_cam_we, 0);
    check("t3_ram_addr", last_ram_addr, 1);
    check("t3_hit", obs_hit, 0);
    check("t3_dst", obs_dst, 16'h0045);

    // Multicast source: no learning
    run_req(MAC_MC, 16'h0002, MAC_A, 0, 0);
    check("mc_lat", lat, 4);
    check("mc_camwe", n_cam_we, 0);
    check("mc_ramwe", n_ram_we, 0);
    check("mc_hit", obs_hit, 1);
    check("mc_dst", obs_dst, 16'h0004);

    // From CPU (port 0), unknown destination
    run_req(MAC_C, 16'h0000, MAC_D, 0, 0);
    check("cpu_hit", obs_hit, 0);
    check("cpu_dst", obs_dst, 16'h0055);

    // Fresh start, learn 17 MACs to wrap wr_ptr
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      run_req(MAC_M + 48'(i), 16'h0002, MAC_BC, 0, 0);
      if (i == 15) check("t4_addr15", last_cam_addr, 15);
      if (i == 16) check("t4_addr16", last_cam_addr, 0);
    end
    run_req(MAC_M + 48'd2, 16'h0008, MAC_M, 0, 0);
    check("t4_old_hit", obs_hit, 0);
    check("t4_old_dst", obs_dst, 16'h0055);
    run_req(MAC_M + 48'd2, 16'h0008, MAC_M + 48'd16, 0, 0);
    check("t4_new_hit", obs_hit, 1);
    check("t4_new_dst", obs_dst, 16'h0002);

    // CAM busy for 20 cycles during source compare
    run_req(MAC_E, 16'h0001, MAC_BC, 20, 0);
    check("t5_done", seen_done, 1);
    check("t5_camwe_c", first_cam_we_c, 16);
    check("t5_cam_addr", last_cam_addr, 1);
    check("t5_lat", lat, 23);
    check("t5_hit", obs_hit, 0);
    check("t5_dst", obs_dst, 16'h0054);

    // Reset during RAM_RD
    run_req(MAC_M + 48'd3, 16'h0008, MAC_M + 48'd16, 0, 4);
    check("t6_nodone", seen_done, 0);
    @(negedge clk);
    check_idle("t6");
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t6_post_done", lkup_done, 0);
    end
    run_req(MAC_F, 16'h0001, MAC_BC, 0, 0);
    check("t6_lat", lat, 6);
    check("t6_wrptr0", last_cam_addr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
